// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, decode handshake and redirect.
// master = fetch_queue, slave = memory/decode/branch side.
interface fetch_queue_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  in_mem_addr;
  logic               in_mem_en;
  logic [INSTR_W-1:0] in_mem;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  instr_pc;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [CNT_W-1:0]   occupancy;

  modport master (
    output in_mem_addr, in_mem_en, instr_valid, instruction, instr_pc, occupancy,
    input  in_mem, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  in_mem_addr, in_mem_en, instr_valid, instruction, instr_pc, occupancy,
    output in_mem, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: one request in flight, DEPTH-entry {pc, instr} queue.
// Optional same-cycle bypass of a returning word to decode: `define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic               inflight_q, inflight_d;
  logic               drop_q, drop_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic               fifo_empty;
  logic               returning;
  logic               bypass;
  logic               valid;
  logic               pop;
  logic               pop_fifo;
  logic               push;
  logic               issue;
  logic [CNT_W:0]     pending;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    fifo_empty = (count_q == '0);
    returning  = inflight_q & ~drop_q;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass     = returning & fifo_empty & ~bus.redirect;
`else
    bypass     = 1'b0;
`endif
    valid      = ~fifo_empty | bypass;
    pop        = valid & bus.instr_ready;
    pop_fifo   = pop & ~fifo_empty & ~bus.redirect;
    // A bypassed word that decode accepts never enters the queue.
    push       = returning & ~bus.redirect & ~(bypass & bus.instr_ready);
    pending    = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    issue      = ~bus.redirect & (pending < (CNT_W+1)'(DEPTH));
  end

  always_comb begin
    bus.in_mem_en   = issue & ~reset;
    bus.in_mem_addr = pc_q;
    bus.instr_valid = valid;
    bus.occupancy   = count_q;
    bus.instruction = '0;
    bus.instr_pc    = '0;
    if (!fifo_empty) begin
      bus.instruction = instr_mem[rd_ptr_q];
      bus.instr_pc    = pc_mem[rd_ptr_q];
    end else if (bypass) begin
      bus.instruction = bus.in_mem;
      bus.instr_pc    = inflight_pc_q;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    drop_d        = bus.redirect & issue;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (issue) begin
      inflight_pc_d = pc_q;
      pc_d          = pc_q + ADDR_W'(PC_STEP);
    end
    if (bus.redirect) begin
      pc_d     = bus.redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_fifo);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop_fifo);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      drop_q        <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      drop_q        <= drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // NOTE: queue storage is not reset; count_q gates every read, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= inflight_pc_q;
      instr_mem[wr_ptr_q] <= bus.in_mem;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, reset cases and
// randomized traffic against a queue-based reference model.
module tb_fetch_queue;
  localparam int          AW    = 32;
  localparam int          IW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'hA5A5_A5A5;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_queue_if #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: fixed 1-cycle latency, data = address ^ K.
  always @(posedge clk)
    bus.in_mem <= bus.in_mem_en ? (bus.in_mem_addr ^ K) : 32'hDEAD_BEEF;

  typedef struct {
    logic        rdy;
    logic        rdr;
    logic [31:0] rpc;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [2:0]  occ;
  } vec_t;

  // Reference model: fetch PC, one optional in-flight address, queue of PCs.
  logic [31:0] m_pc, m_ipc;
  bit          m_infl, m_pop, m_byp;
  logic [31:0] mq[$];
  logic        e_en, e_valid;
  logic [31:0] e_addr, e_pc, e_instr;
  logic [2:0]  e_occ;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic en, input logic [31:0] addr,
                            input logic vld, input logic [31:0] pc,
                            input logic [31:0] instr, input logic [2:0] occ);
    check({tag, ".en"},    64'(bus.in_mem_en),   64'(en));
    check({tag, ".addr"},  64'(bus.in_mem_addr), 64'(addr));
    check({tag, ".valid"}, 64'(bus.instr_valid), 64'(vld));
    check({tag, ".pc"},    64'(bus.instr_pc),    64'(pc));
    check({tag, ".instr"}, 64'(bus.instruction), 64'(instr));
    check({tag, ".occ"},   64'(bus.occupancy),   64'(occ));
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_ipc  = 32'h0;
    m_infl = 1'b0;
    mq.delete();
  endtask

  task automatic model_eval(input bit rdy, input bit rdr);
    int sz;
    sz      = mq.size();
    m_byp   = BYP && m_infl && (sz == 0) && !rdr;
    e_valid = (sz > 0) || m_byp;
    e_pc    = (sz > 0) ? mq[0] : (m_byp ? m_ipc : 32'h0);
    e_instr = e_valid ? (e_pc ^ K) : 32'h0;
    m_pop   = e_valid && rdy;
    e_en    = !rdr && ((sz + int'(m_infl) - int'(m_pop)) < DEPTH);
    e_addr  = m_pc;
    e_occ   = 3'(sz);
  endtask

  task automatic model_step(input bit rdy, input bit rdr, input logic [31:0] rpc);
    if (rdr) begin
      mq.delete();
      m_pc   = rpc;
      m_infl = 1'b0;
    end else begin
      if (m_pop && mq.size() > 0) void'(mq.pop_front());
      if (m_infl && !(m_byp && rdy)) mq.push_back(m_ipc);
      if (e_en) begin
        m_ipc  = m_pc;
        m_pc   = m_pc + 32'd4;
        m_infl = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
  endtask

  // Holds reset over two edges, checks reset values, releases just after an edge.
  task automatic do_reset();
    reset           = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_random(input int n);
    bit          rdy, rdr;
    logic [31:0] rpc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rdy = ($urandom_range(0, 2) != 0);
      rdr = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & ~32'h3);
      bus.instr_ready = rdy;
      bus.redirect    = rdr;
      bus.redirect_pc = rpc;
      #1;
      model_eval(rdy, rdr);
      check_outs("rand", e_en, e_addr, e_valid, e_pc, e_instr, e_occ);
      @(posedge clk);
      model_step(rdy, rdr, rpc);
    end
  endtask

  function automatic vec_t vec(input bit rdy, input bit rdr, input logic [31:0] rpc,
                               input bit en, input logic [31:0] addr, input bit vld,
                               input logic [31:0] pc, input int occ);
    vec_t v;
    v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
    v.en = en; v.addr = addr; v.vld = vld; v.pc = pc; v.occ = 3'(occ);
    return v;
  endfunction

  vec_t tbl[25];

  initial begin
    // Cycle 0 is the first cycle after reset release.
    tbl[0]  = vec(1, 0, 0, 1, 32'h00, 0, 32'h00, 0);
    tbl[1]  = vec(1, 0, 0, 1, 32'h04, 0, 32'h00, 0);
    tbl[2]  = vec(1, 0, 0, 1, 32'h08, 1, 32'h00, 1);
    tbl[3]  = vec(1, 0, 0, 1, 32'h0C, 1, 32'h04, 1);
    tbl[4]  = vec(0, 0, 0, 1, 32'h10, 1, 32'h08, 1);
    tbl[5]  = vec(0, 0, 0, 1, 32'h14, 1, 32'h08, 2);
    tbl[6]  = vec(0, 0, 0, 0, 32'h18, 1, 32'h08, 3);
    for (int i = 7; i <= 13; i++) tbl[i] = vec(0, 0, 0, 0, 32'h18, 1, 32'h08, 4);
    tbl[14] = vec(1, 0, 0, 1, 32'h18, 1, 32'h08, 4);
    tbl[15] = vec(1, 0, 0, 1, 32'h1C, 1, 32'h0C, 3);
    tbl[16] = vec(1, 0, 0, 1, 32'h20, 1, 32'h10, 3);
    tbl[17] = vec(1, 1, 32'h100, 0, 32'h24, 1, 32'h14, 3);
    tbl[18] = vec(1, 0, 0, 1, 32'h100, 0, 32'h00, 0);
    tbl[19] = vec(1, 0, 0, 1, 32'h104, 0, 32'h00, 0);
    tbl[20] = vec(1, 0, 0, 1, 32'h108, 1, 32'h100, 1);
    tbl[21] = vec(1, 1, 32'hFFFF_FFFC, 0, 32'h10C, 1, 32'h104, 1);
    tbl[22] = vec(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h00, 0);
    tbl[23] = vec(1, 0, 0, 1, 32'h0000_0000, 0, 32'h00, 0);
    tbl[24] = vec(1, 0, 0, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC, 1);

    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    do_reset();
`ifndef FETCH_QUEUE_BYPASS_EN
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      bus.instr_ready = tbl[i].rdy;
      bus.redirect    = tbl[i].rdr;
      bus.redirect_pc = tbl[i].rpc;
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].en, tbl[i].addr, tbl[i].vld, tbl[i].pc,
                 tbl[i].vld ? (tbl[i].pc ^ K) : 32'h0, tbl[i].occ);
    end
`endif

    do_reset();
    run_random(300);

    // Asynchronous reset between edges: outputs must clear before the next edge.
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_outs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    run_random(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end that replaces the single-register fetch stage. It drives the instruction-memory address/enable, tracks the one request in flight, and buffers returned words with their PCs in a DEPTH-entry FIFO. Decode pulls instructions through a valid/ready handshake. Control-flow redirects flush the queue and discard the stale in-flight word. The block sits between instruction memory and the decoder in the core top level.

## Interface
- ADDR_W, 32, PC / memory address width
- INSTR_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- PC_STEP, 4, PC increment per fetched word, in address units
- clk  input  1  main clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_mem_addr  output  ADDR_W  instruction memory address
- in_mem_en  output  1  fetch request this cycle
- in_mem  input  INSTR_W  memory read data; valid exactly 1 cycle after the request
- instr_valid  output  1  head entry available to decode
- instr_ready  input  1  decode accepts head this cycle
- instruction  output  INSTR_W  head instruction
- instr_pc  output  ADDR_W  address of the head instruction
- redirect  input  1  branch/jump taken; flush
- redirect_pc  input  ADDR_W  new fetch address
- occupancy  output  $clog2(DEPTH)+1  valid entries in the queue

## Operation
- State: fetch PC, inflight flag, inflight_pc, drop flag, FIFO of {pc, instr}, read/write pointers, count.
- pop = instr_valid & instr_ready.
- Issue: in_mem_en = !redirect & (count + inflight − pop < DEPTH). in_mem_addr = fetch PC. On issue: inflight_pc ← PC, PC ← PC + PC_STEP (mod 2^ADDR_W, wraps silently), inflight ← 1. With no issue, inflight ← 0.
- Return: when inflight was set last cycle and drop is clear, {inflight_pc, in_mem} is pushed. Drop set → word discarded.
- Redirect, which has highest priority: FIFO emptied (count ← 0, pointers ← 0), PC ← redirect_pc, no issue this cycle, drop ← 1 if a response returns next cycle. A same-cycle pop is ignored. A same-cycle returning word is discarded.
- Push and pop in the same cycle: count unchanged. Push is never attempted when full; the issue rule guarantees this.
- Empty: instr_valid = 0, and instruction/instr_pc hold 0.
- Reset mid-operation: everything returns to reset values immediately. A response arriving after reset is ignored, because inflight = 0.

## Timing
- Reset values: in_mem_addr = RESET_PC, in_mem_en = 0, instr_valid = 0, instruction = 0, instr_pc = 0, occupancy = 0.
- First cycle after reset deasserts: in_mem_en = 1 at RESET_PC.
- Fetch-to-decode latency, without bypass: 2 cycles (request edge → data captured → valid).
- With instr_ready held high: one instruction per cycle sustained.
- Redirect in cycle N: request at redirect_pc in N+1. Valid in N+3, or in N+2 with bypass.
- Memory latency is fixed at 1 cycle. Memory never stalls.
- in_mem_en depends combinationally on instr_ready and redirect.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when the FIFO is empty and a non-dropped word returns, it is presented on instruction/instr_pc with instr_valid = 1 in the same cycle.
  - If accepted, it is not written into the FIFO.
  - If not accepted, it is pushed.
  - Fetch-to-decode latency becomes 1 cycle.
  - A redirect in that cycle still discards the word, and instr_valid = 0.
- Undefined: returned words are always pushed and are visible the following cycle. instr_valid is purely registered.

## Test plan
- Reset release, instr_ready = 1, memory returns addr^0xA5A5A5A5 → first instr_pc = 0 at cycle 2 (cycle 1 with bypass), then 4, 8, 12… at one per cycle.
- instr_ready = 0 for 10 cycles → occupancy saturates at 4; in_mem_en drops to 0 once count + inflight = 4; no word is lost. Raise ready → PCs are delivered in order, with no gaps or duplicates.
- Redirect to 0x100 while the queue holds 3 entries and one word is in flight → occupancy = 0 next cycle; the stale word is dropped; the next delivered instr_pc = 0x100.
- Redirect asserted in the same cycle as a pop and a returning word → no instruction delivered that cycle is counted as consumed. The next instruction delivered has pc = redirect_pc.
- PC = 0xFFFFFFFC with PC_STEP = 4 → next fetch address is 0x00000000.
- Reset asserted asynchronously mid-stream → all outputs return to reset values before the next edge; fetch restarts at RESET_PC.
